// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding select and stall/bubble/flush generator with a shadow of ID/EX, EX/MEM, MEM/WB fields.
// Optional HAZARD_STATS_EN adds saturating stall_count / flush_count outputs.
module hazard_forward_unit #(
  parameter int unsigned REG_BITS  = 5,
  parameter int unsigned STAT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic [REG_BITS-1:0] id_dst,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                ex_branch_taken,
  output logic [1:0]          ForwardA,
  output logic [1:0]          ForwardB,
  output logic                stall,
  output logic                bubble_id_ex,
  output logic                flush_if_id
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_BITS-1:0] stall_count,
  output logic [STAT_BITS-1:0] flush_count
`endif
);

  logic [REG_BITS-1:0] r_ex_rs;
  logic [REG_BITS-1:0] r_ex_rt;
  logic [REG_BITS-1:0] r_ex_dst;
  logic                r_ex_wr;
  logic                r_ex_mr;
  logic                r_ex_use_rs;
  logic                r_ex_use_rt;
  logic [REG_BITS-1:0] r_mem_dst;
  logic                r_mem_wr;
  logic [REG_BITS-1:0] r_wb_dst;
  logic                r_wb_wr;

  logic w_load_use;
  logic w_mem_match_rs;
  logic w_mem_match_rt;
  logic w_wb_match_rs;
  logic w_wb_match_rt;

  // Register 0 is hardwired, so a writer of $0 never produces a forward.
  assign w_mem_match_rs = r_mem_wr && (r_mem_dst != '0) && (r_mem_dst == r_ex_rs) && r_ex_use_rs;
  assign w_mem_match_rt = r_mem_wr && (r_mem_dst != '0) && (r_mem_dst == r_ex_rt) && r_ex_use_rt;
  assign w_wb_match_rs  = r_wb_wr  && (r_wb_dst  != '0) && (r_wb_dst  == r_ex_rs) && r_ex_use_rs;
  assign w_wb_match_rt  = r_wb_wr  && (r_wb_dst  != '0) && (r_wb_dst  == r_ex_rt) && r_ex_use_rt;

  assign w_load_use = r_ex_mr && r_ex_wr && (r_ex_dst != '0) && id_valid &&
                      ((id_uses_rs && (id_rs == r_ex_dst)) ||
                       (id_uses_rt && (id_rt == r_ex_dst)));

  always_comb begin
    ForwardA = 2'b00;
    ForwardB = 2'b00;
    if (w_mem_match_rs) begin
      ForwardA = 2'b10;
    end else if (w_wb_match_rs) begin
      ForwardA = 2'b01;
    end
    if (w_mem_match_rt) begin
      ForwardB = 2'b10;
    end else if (w_wb_match_rt) begin
      ForwardB = 2'b01;
    end
  end

  // A taken branch squashes the ID instruction, so any load-use stall is moot.
  always_comb begin
    stall        = w_load_use && !ex_branch_taken;
    bubble_id_ex = w_load_use || ex_branch_taken;
    flush_if_id  = ex_branch_taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_rs     <= '0;
      r_ex_rt     <= '0;
      r_ex_dst    <= '0;
      r_ex_wr     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_use_rs <= 1'b0;
      r_ex_use_rt <= 1'b0;
      r_mem_dst   <= '0;
      r_mem_wr    <= 1'b0;
      r_wb_dst    <= '0;
      r_wb_wr     <= 1'b0;
    end else begin
      r_mem_dst <= r_ex_dst;
      r_mem_wr  <= r_ex_wr;
      r_wb_dst  <= r_mem_dst;
      r_wb_wr   <= r_mem_wr;
      if (bubble_id_ex) begin
        r_ex_rs     <= '0;
        r_ex_rt     <= '0;
        r_ex_dst    <= '0;
        r_ex_wr     <= 1'b0;
        r_ex_mr     <= 1'b0;
        r_ex_use_rs <= 1'b0;
        r_ex_use_rt <= 1'b0;
      end else begin
        r_ex_rs     <= id_rs;
        r_ex_rt     <= id_rt;
        r_ex_dst    <= id_dst;
        r_ex_wr     <= id_valid && id_reg_write;
        r_ex_mr     <= id_valid && id_mem_read;
        r_ex_use_rs <= id_valid && id_uses_rs;
        r_ex_use_rt <= id_valid && id_uses_rt;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_BITS-1:0] r_stall_count;
  logic [STAT_BITS-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + STAT_BITS'(1);
      end
      if (flush_if_id && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + STAT_BITS'(1);
      end
    end
  end

  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;
`else
  logic [STAT_BITS-1:0] w_stats_unused;
  assign w_stats_unused = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector table, reset/stall sequences, and random stimulus vs a pipeline model.
module tb_hazard_forward_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       ex_branch_taken;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       stall;
  logic       bubble_id_ex;
  logic       flush_if_id;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  hazard_forward_unit #(.REG_BITS(5), .STAT_BITS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_dst          (id_dst),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ForwardA        (ForwardA),
    .ForwardB        (ForwardB),
    .stall           (stall),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dst;
    logic       wr;
    logic       mr;
    logic       br;
  } in_t;

  typedef struct {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       bu;
    logic       fl;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  // Model: one slot per in-flight instruction, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       wr;
    logic       mr;
    logic       urs;
    logic       urt;
  } slot_t;

  slot_t       pipe [3];
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;
  int          total;
  int          bad;

  function automatic in_t mk_in(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                                logic [4:0] dst, logic wr, logic mr, logic br);
    in_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.dst = dst; r.wr = wr; r.mr = mr; r.br = br;
    return r;
  endfunction

  function automatic out_t mk_out(logic [1:0] fa, logic [1:0] fb, logic st, logic bu, logic fl);
    out_t r;
    r.fa = fa; r.fb = fb; r.st = st; r.bu = bu; r.fl = fl;
    return r;
  endfunction

  // Youngest older producer of a register supplies the operand; $0 never forwards.
  function automatic logic [1:0] m_fwd(logic [4:0] r, logic used);
    if (!used || r == 5'd0) return 2'b00;
    for (int k = 1; k <= 2; k++) begin
      if (pipe[k].wr && pipe[k].dst == r) return (k == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic out_t model_out(in_t v);
    out_t  o;
    logic  lu;
    lu = pipe[0].mr && pipe[0].wr && pipe[0].dst != 5'd0 && v.v &&
         ((v.urs && v.rs == pipe[0].dst) || (v.urt && v.rt == pipe[0].dst));
    o.fa = m_fwd(pipe[0].rs, pipe[0].urs);
    o.fb = m_fwd(pipe[0].rt, pipe[0].urt);
    o.st = lu && !v.br;
    o.bu = lu || v.br;
    o.fl = v.br;
    return o;
  endfunction

  task automatic check(string nm, out_t exp);
    total++;
    if (ForwardA !== exp.fa || ForwardB !== exp.fb || stall !== exp.st ||
        bubble_id_ex !== exp.bu || flush_if_id !== exp.fl) begin
      bad++;
      $display("FAIL %s: got fa=%b fb=%b st=%b bu=%b fl=%b, want fa=%b fb=%b st=%b bu=%b fl=%b",
               nm, ForwardA, ForwardB, stall, bubble_id_ex, flush_if_id,
               exp.fa, exp.fb, exp.st, exp.bu, exp.fl);
    end
  endtask

  task automatic check_val(string nm, int unsigned got, int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  // mode 0: no check, 1: check against texp, 2: check against model
  task automatic run_cycle(in_t v, logic rst, int mode, out_t texp, string nm);
    out_t  mexp;
    slot_t s;
    @(negedge clk);
    reset           = rst;
    id_valid        = v.v;
    id_rs           = v.rs;
    id_rt           = v.rt;
    id_uses_rs      = v.urs;
    id_uses_rt      = v.urt;
    id_dst          = v.dst;
    id_reg_write    = v.wr;
    id_mem_read     = v.mr;
    ex_branch_taken = v.br;
    #1;
    mexp = model_out(v);
    if (mode == 1) check(nm, texp);
    else if (mode == 2) check(nm, mexp);
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (mexp.st && m_stall_cnt != 32'hFFFF) m_stall_cnt++;
      if (mexp.fl && m_flush_cnt != 32'hFFFF) m_flush_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      s = '{default: '0};
      if (!mexp.bu && v.v) begin
        s.rs = v.rs; s.rt = v.rt; s.dst = v.dst;
        s.wr = v.wr; s.mr = v.mr; s.urs = v.urs; s.urt = v.urt;
      end
      pipe[0] = s;
    end
  endtask

  vec_t tab [25];
  in_t  nop;
  out_t zero;
  in_t  ri;

  initial begin
    total = 0;
    bad   = 0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    for (int k = 0; k < 3; k++) pipe[k] = '{default: '0};
    nop  = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    zero = mk_out(2'b00, 2'b00, 0, 0, 0);

    // Each row is what sits in ID this cycle and the outputs expected during it.
    tab[0]  = '{mk_in(1, 1, 2, 1, 1,  8, 1, 0, 0), zero};               // add $8
    tab[1]  = '{mk_in(1, 8, 9, 1, 1, 10, 1, 0, 0), zero};               // add $10 <- $8,$9
    tab[2]  = '{nop, mk_out(2'b10, 2'b00, 0, 0, 0)};                    // EX/MEM -> A
    tab[3]  = '{mk_in(1, 1, 2, 1, 1,  8, 1, 0, 0), zero};               // add $8
    tab[4]  = '{nop, zero};
    tab[5]  = '{mk_in(1, 9, 8, 1, 1, 11, 1, 0, 0), zero};               // sub <- $9,$8
    tab[6]  = '{nop, mk_out(2'b00, 2'b01, 0, 0, 0)};                    // MEM/WB -> B
    tab[7]  = '{mk_in(1, 1, 2, 1, 1,  8, 1, 0, 0), zero};
    tab[8]  = '{mk_in(1, 1, 2, 1, 1,  8, 1, 0, 0), zero};
    tab[9]  = '{mk_in(1, 8, 3, 1, 1, 12, 1, 0, 0), zero};
    tab[10] = '{nop, mk_out(2'b10, 2'b00, 0, 0, 0)};                    // MEM priority
    tab[11] = '{mk_in(1, 1, 0, 1, 0,  8, 1, 1, 0), zero};               // lw $8
    tab[12] = '{mk_in(1, 8, 4, 1, 1, 13, 1, 0, 0), mk_out(2'b00, 2'b00, 1, 1, 0)};
    tab[13] = '{mk_in(1, 8, 4, 1, 1, 13, 1, 0, 0), zero};               // held, bubble in EX
    tab[14] = '{nop, mk_out(2'b01, 2'b00, 0, 0, 0)};                    // load via MEM/WB
    tab[15] = '{mk_in(1, 1, 0, 1, 0,  8, 1, 1, 0), zero};               // lw $8
    tab[16] = '{mk_in(1, 8, 8, 1, 1, 14, 1, 0, 1), mk_out(2'b00, 2'b00, 0, 1, 1)};
    tab[17] = '{nop, zero};
    tab[18] = '{mk_in(1, 1, 2, 1, 1,  0, 1, 0, 0), zero};               // writer of $0
    tab[19] = '{mk_in(1, 0, 0, 1, 1, 15, 1, 0, 0), zero};
    tab[20] = '{mk_in(1, 0, 0, 1, 1, 15, 1, 0, 0), zero};               // $0 in MEM
    tab[21] = '{nop, zero};                                             // $0 in WB
    tab[22] = '{mk_in(1, 1, 0, 1, 0,  0, 1, 1, 0), zero};               // lw $0
    tab[23] = '{mk_in(1, 0, 0, 1, 1, 16, 1, 0, 0), zero};               // no stall on $0
    tab[24] = '{nop, zero};

    run_cycle(nop, 1'b1, 0, zero, "rst0");
    run_cycle(nop, 1'b1, 0, zero, "rst1");
    run_cycle(nop, 1'b0, 1, zero, "reset_state");
    run_cycle(nop, 1'b0, 1, zero, "reset_state2");

    for (int i = 0; i < 25; i++) begin
      run_cycle(tab[i].i, 1'b0, 1, tab[i].o, $sformatf("vec%0d", i));
    end

    // Reset arriving during a load-use stall.
    run_cycle(nop, 1'b0, 2, zero, "pre_lu_nop");
    run_cycle(mk_in(1, 1, 0, 1, 0, 8, 1, 1, 0), 1'b0, 2, zero, "pre_lu_lw");
    run_cycle(mk_in(1, 8, 4, 1, 1, 13, 1, 0, 0), 1'b1, 1, mk_out(2'b00, 2'b00, 1, 1, 0), "stall_at_reset");
    run_cycle(mk_in(1, 8, 4, 1, 1, 13, 1, 0, 0), 1'b0, 1, zero, "after_reset_mid_stall");

    // Three independent load-use stalls.
    for (int n = 0; n < 3; n++) begin
      run_cycle(mk_in(1, 1, 0, 1, 0, 9, 1, 1, 0), 1'b0, 2, zero, "lw9");
      run_cycle(mk_in(1, 2, 9, 1, 1, 17, 1, 0, 0), 1'b0, 1, mk_out(2'b00, 2'b00, 1, 1, 0), "lu_stall");
      run_cycle(mk_in(1, 2, 9, 1, 1, 17, 1, 0, 0), 1'b0, 1, zero, "lu_release");
    end
    run_cycle(nop, 1'b0, 1, mk_out(2'b00, 2'b01, 0, 0, 0), "lu_fwd_b");
`ifdef HAZARD_STATS_EN
    check_val("stall_count_3", stall_count, 3);
    check_val("flush_count_0", flush_count, 0);
`endif

    for (int n = 0; n < 3000; n++) begin
      ri.v   = ($urandom_range(0, 99) < 85);
      ri.rs  = 5'($urandom_range(0, 3));
      ri.rt  = 5'($urandom_range(0, 3));
      ri.urs = 1'($urandom_range(0, 1));
      ri.urt = 1'($urandom_range(0, 1));
      ri.dst = 5'($urandom_range(0, 3));
      ri.wr  = ($urandom_range(0, 99) < 80);
      ri.mr  = ($urandom_range(0, 99) < 35);
      ri.br  = ($urandom_range(0, 99) < 10);
      run_cycle(ri, ($urandom_range(0, 199) == 0), 2, zero, $sformatf("rand%0d", n));
    end
    run_cycle(nop, 1'b0, 2, zero, "rand_tail");
`ifdef HAZARD_STATS_EN
    check_val("stall_count_rand", stall_count, m_stall_cnt);
    check_val("flush_count_rand", flush_count, m_flush_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
